led_trail_pwm: RTL and testbench
================================

// Module: led_trail_pwm
// PURPOSE
//  Downstream stage of the water-LED rotator: consumes its 12-bit one-hot pattern and drives the
//  physical LED pins with PWM so each LED fades out behind the moving dot ("comet trail").
//  Per-LED brightness levels are set to full when the pattern lights an LED and decay stepwise afterwards.
//  Sits between the pattern generator and the board LED pins; all outputs are registered.
// PARAMETERS
//  N_LED       12         number of LEDs / pattern width
//  LEVEL_W     4          brightness level width; LEVEL_MAX = 2**LEVEL_W-1 = 15
//  PWM_DIV     500        clk cycles per PWM slot (prescaler terminal count +1), >=1
//  DECAY_STEP  3          level decrement per decay event, 1..LEVEL_MAX
//  DECAY_DIV   1_250_000  clk cycles between periodic decay ticks, >=2
// PORTS
//  clk          in   1      system clock
//  rst_n        in   1      reset, asynchronous, active-low
//  en           in   1      block enable; 0 = blank and clear
//  pattern_in   in   N_LED  LED pattern from rotator (any bit combination legal)
//  led_pwm      out  N_LED  PWM drive to LED pins, 1 = on
//  frame_start  out  1      one-cycle pulse at start of each PWM frame
// BEHAVIOUR
//  Reset: led_pwm=0, frame_start=0, all levels=0, pattern_q=0, all counters=0.
//  Prescaler: pre_cnt counts 0..PWM_DIV-1 and wraps; slot_end = (pre_cnt==PWM_DIV-1).
//  PWM slot counter: pwm_cnt 0..LEVEL_MAX-1 (0..14), increments on slot_end, wraps 14->0.
//  frame_start=1 for exactly the cycle after the slot_end on which pwm_cnt wrapped 14->0.
//  Decay timer: dec_cnt 0..DECAY_DIV-1, free-running; decay_tick = (dec_cnt==DECAY_DIV-1).
//  Change detect: pattern_q <= pattern_in each cycle; chg = (pattern_in != pattern_q).
//  Decay event dec_ev = chg | decay_tick (coincident chg and tick = ONE decrement, not two).
//  Level update per LED i, registered, priority order:
//   1. pattern_in[i]==1         -> level[i] <= LEVEL_MAX (held at max while bit stays set)
//   2. dec_ev                   -> level[i] <= sat0(level[i]-DECAY_STEP), unsigned, floor 0
//   3. otherwise                -> hold
//  Output: led_pwm[i] <= (level[i] > pwm_cnt); level 15 = always on, level 0 = always off,
//   level L = on for L of 15 slots.
//  Latency: pattern_in bit rises at cycle t -> level=15 at t+1 -> led_pwm[i]=1 at t+2.
//  en=0: synchronous clear; levels, pre_cnt, pwm_cnt, dec_cnt, pattern_q -> 0; led_pwm=0;
//   frame_start=0. On en 0->1 counters restart from 0; first frame_start after 15*PWM_DIV cycles.
//  Async reset mid-frame: all state to reset values immediately; no partial-frame recovery.
//  pattern_in all-zero: every LED decays to 0 and stays dark; no error condition.
//  Multiple bits set: each set bit independently held at LEVEL_MAX.
// STRUCTURE
//  Shared header led_pkg.vh: N_LED, LEVEL_W, LEVEL_MAX, sat-subtract function sat_sub.
//  Sub-module pwm_timebase: pre_cnt + pwm_cnt + frame_start generation (params PWM_DIV, LEVEL_MAX).
//  Top: change detect, decay timer, level array (generate loop over N_LED), output compare regs.
// TESTING (bench params: PWM_DIV=2, DECAY_DIV=8, DECAY_STEP=3)
//  1 Reset: hold rst_n=0, pattern_in=12'h001 -> led_pwm=0, frame_start=0; release -> LED0 level 15
//    two cycles later, led_pwm[0]=1 continuously, all others 0.
//  2 Timebase: en=1, no pattern -> frame_start pulses every 30 cycles, exactly 1 cycle wide.
//  3 Trail: pattern 12'h001 -> 12'h002 at cycle t -> level[0]=12 at t+1, then 9,6,3,0 on each
//    8-cycle decay_tick; led_pwm[0] duty = 12/15,9/15.. measured per frame.
//  4 Coincidence: align pattern change with decay_tick -> level[0] drops 15->12 (single step only).
//  5 Wrap: rotate 12'h800 -> 12'h001 -> LED11 decays, LED0 set 15; no glitch on other LEDs.
//  6 Enable/reset mid-frame: drop en (or pulse rst_n) at pwm_cnt=7 -> led_pwm=0 next cycle,
//    levels 0; re-enable -> frame_start 30 cycles later.

Source files
------------

// File: rtl/led_trail_pwm_pkg.sv
// Shared constants and helpers for the LED comet-trail PWM stage.
// Brightness levels are LEVEL_W-bit unsigned values, 0 = dark, LEVEL_MAX = full.
package led_trail_pwm_pkg;

    localparam int N_LED     = 12;
    localparam int LEVEL_W   = 4;
    localparam int LEVEL_MAX = (1 << LEVEL_W) - 1;

    typedef logic [LEVEL_W-1:0] level_t;

    function automatic level_t sat_sub(input level_t a, input level_t b);
        return (a > b) ? level_t'(a - b) : '0;
    endfunction

endpackage

// File: rtl/led_trail_pwm_timebase.sv
// PWM timebase: prescaler, slot counter (0..LEVEL_MAX-1) and frame_start pulse.
// en=0 holds everything at zero so the next frame starts cleanly.
module led_trail_pwm_timebase
    import led_trail_pwm_pkg::*;
#(
    parameter int PWM_DIV = 500
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en,
    output level_t pwm_cnt_o,
    output logic   frame_start_o
);

    localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

    logic [PW-1:0] pre_q, pre_d;
    level_t        pwm_q, pwm_d;
    logic          fs_q, fs_d;
    logic          slot_end;

    always_comb begin
        slot_end = (pre_q == PW'(PWM_DIV - 1));
        pre_d    = slot_end ? '0 : pre_q + 1'b1;
        pwm_d    = pwm_q;
        fs_d     = slot_end && (pwm_q == level_t'(LEVEL_MAX - 1));
        if (slot_end) begin
            pwm_d = fs_d ? '0 : pwm_q + 1'b1;
        end
        if (!en) begin
            pre_d = '0;
            pwm_d = '0;
            fs_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
            pwm_q <= '0;
            fs_q  <= 1'b0;
        end else begin
            pre_q <= pre_d;
            pwm_q <= pwm_d;
            fs_q  <= fs_d;
        end
    end

    assign pwm_cnt_o     = pwm_q;
    assign frame_start_o = fs_q;

endmodule

// File: rtl/led_trail_pwm.sv
// Comet-trail PWM driver: lit LEDs jump to full brightness, then fade stepwise
// on every pattern change or periodic decay tick.
module led_trail_pwm
    import led_trail_pwm_pkg::*;
#(
    parameter int PWM_DIV    = 500,
    parameter int DECAY_STEP = 3,
    parameter int DECAY_DIV  = 1_250_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_LED-1:0] pattern_in,
    output logic [N_LED-1:0] led_pwm,
    output logic             frame_start
);

    localparam int     DW   = $clog2(DECAY_DIV);
    localparam level_t STEP = level_t'(DECAY_STEP);

    logic [DW-1:0]                  dec_q, dec_d;
    logic [N_LED-1:0]               pat_q;
    logic [N_LED-1:0][LEVEL_W-1:0]  lvl_q, lvl_d;
    logic [N_LED-1:0]               led_q, led_d;
    level_t                         pwm_cnt;
    logic                           decay_tick;
    logic                           dec_ev;

    led_trail_pwm_timebase #(
        .PWM_DIV(PWM_DIV)
    ) u_tb (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .pwm_cnt_o    (pwm_cnt),
        .frame_start_o(frame_start)
    );

    assign decay_tick = (dec_q == DW'(DECAY_DIV - 1));
    assign dec_d      = (!en || decay_tick) ? '0 : dec_q + 1'b1;
    // A change coinciding with a tick still yields a single decrement.
    assign dec_ev     = (pattern_in != pat_q) | decay_tick;

    for (genvar i = 0; i < N_LED; i++) begin : g_led
        assign lvl_d[i] = !en           ? '0
                        : pattern_in[i] ? level_t'(LEVEL_MAX)
                        : dec_ev        ? sat_sub(lvl_q[i], STEP)
                        :                 lvl_q[i];
        assign led_d[i] = en && (lvl_q[i] > pwm_cnt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_q <= '0;
            pat_q <= '0;
            lvl_q <= '0;
            led_q <= '0;
        end else begin
            dec_q <= dec_d;
            pat_q <= en ? pattern_in : '0;
            lvl_q <= lvl_d;
            led_q <= led_d;
        end
    end

    assign led_pwm = led_q;

endmodule

// File: tb/tb_led_trail_pwm.sv
// Self-checking bench for led_trail_pwm against a cycle-count reference model.
// Slot, frame and decay timing are derived arithmetically from cycles since enable.
module tb_led_trail_pwm;

    localparam int PWM_DIV    = 2;
    localparam int DECAY_DIV  = 8;
    localparam int DECAY_STEP = 3;
    localparam int NL         = 12;
    localparam int LMAX       = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [NL-1:0] pattern_in = '0;
    logic [NL-1:0] led_pwm;
    logic          frame_start;

    led_trail_pwm #(
        .PWM_DIV   (PWM_DIV),
        .DECAY_STEP(DECAY_STEP),
        .DECAY_DIV (DECAY_DIV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .pattern_in (pattern_in),
        .led_pwm    (led_pwm),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int            tests = 0;
    int            fails = 0;
    int            lvl[NL];
    int            k = 0;
    logic [NL-1:0] prev = '0;
    logic [NL-1:0] exp_led = '0;
    logic          exp_fs = 1'b0;
    int            cyc = 0;
    int            last_fs = -1;
    int            fs_period = 0;
    int            fs_count = 0;

    task automatic model_clear();
        for (int i = 0; i < NL; i++) lvl[i] = 0;
        k = 0;
        prev = '0;
        exp_led = '0;
        exp_fs = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [NL-1:0] got,
                       input logic [NL-1:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s got=%h expected=%h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic tick(input logic e, input logic [NL-1:0] p);
        int  slot;
        bit  dtick;
        bit  chg;
        en = e;
        pattern_in = p;
        @(posedge clk);
        if (!rst_n || !e) begin
            model_clear();
        end else begin
            slot = (k / PWM_DIV) % LMAX;
            for (int i = 0; i < NL; i++) exp_led[i] = (lvl[i] > slot);
            exp_fs = ((k % PWM_DIV) == PWM_DIV - 1) && (slot == LMAX - 1);
            dtick = ((k % DECAY_DIV) == DECAY_DIV - 1);
            chg = (p != prev);
            for (int i = 0; i < NL; i++) begin
                if (p[i]) lvl[i] = LMAX;
                else if (chg || dtick) lvl[i] = (lvl[i] > DECAY_STEP) ? lvl[i] - DECAY_STEP : 0;
            end
            prev = p;
            k++;
        end
        cyc++;
        #1;
        chk("led_pwm", led_pwm, exp_led);
        chk("frame_start", {11'b0, frame_start}, {11'b0, exp_fs});
        if (frame_start) begin
            if (last_fs >= 0) fs_period = cyc - last_fs;
            last_fs = cyc;
            fs_count++;
        end
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        chk("async_rst_led", led_pwm, '0);
        chk("async_rst_fs", {11'b0, frame_start}, '0);
    endtask

    initial begin
        logic [NL-1:0] p;
        model_clear();

        // Reset held with a pattern present
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) tick(1'b1, 12'h001);
        chk("reset_led", led_pwm, '0);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) tick(1'b1, 12'h001);
        chk("led0_on", led_pwm, 12'h001);

        // Timebase with no pattern: frame period
        tick(1'b0, '0);
        last_fs = -1;
        fs_count = 0;
        fs_period = 0;
        for (int i = 0; i < 75; i++) tick(1'b1, '0);
        chk("frame_count", NL'(fs_count), NL'(2));
        chk("frame_period", NL'(fs_period), NL'(30));

        // Trail: LED0 fades behind LED1
        for (int i = 0; i < 10; i++) tick(1'b1, 12'h001);
        for (int i = 0; i < 80; i++) tick(1'b1, 12'h002);

        // Coincident change and decay tick
        for (int i = 0; i < 10; i++) tick(1'b1, 12'h001);
        while ((k % DECAY_DIV) != DECAY_DIV - 1) tick(1'b1, 12'h001);
        tick(1'b1, 12'h004);
        for (int i = 0; i < 40; i++) tick(1'b1, 12'h004);

        // Wrap 12'h800 -> 12'h001
        for (int i = 0; i < 10; i++) tick(1'b1, 12'h800);
        for (int i = 0; i < 60; i++) tick(1'b1, 12'h001);

        // Enable drop mid-frame at slot 7
        for (int i = 0; i < 100 && ((k / PWM_DIV) % LMAX) != 7; i++) tick(1'b1, 12'h0F1);
        tick(1'b0, 12'h0F1);
        chk("en_drop_led", led_pwm, '0);
        last_fs = -1;
        fs_count = 0;
        for (int i = 0; i < 31; i++) tick(1'b1, 12'h0F1);
        chk("reen_frame", NL'(fs_count), NL'(1));

        // Async reset mid-frame
        for (int i = 0; i < 100 && ((k / PWM_DIV) % LMAX) != 7; i++) tick(1'b1, 12'h3C0);
        async_reset();
        tick(1'b1, 12'h3C0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) tick(1'b1, 12'h3C0);

        // Randomized rotation, random patterns, occasional enable/reset drops
        p = 12'h001;
        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 30) p = {p[NL-2:0], p[NL-1]};
            else if (r < 36) p = NL'($urandom);
            else if (r < 40) p = '0;
            else if (r < 42) p = 12'h001;
            if (r == 99) begin
                async_reset();
                tick(1'b1, p);
                rst_n = 1'b1;
            end else begin
                tick((r != 98), p);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
